// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Control FSM for a multi-cycle MIPS-subset datapath. Sequences
//               the shared memory port, register file, ALU and PC over several
//               clocks per instruction. Every datapath select and enable is a
//               combinational decode of the state register plus the current
//               opcode/func/zero/mem_ready inputs.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset; also forces all outputs to 0
//   opcode     in   IR[31:26]
//   func       in   IR[5:0]
//   zero       in   ALU zero flag
//   mem_ready  in   memory completes current read/write this cycle
//   pc_en      out  PC load enable
//   pc_src     out  PC source: 0 ALU, 1 ALUOut, 2 jump addr, 3 rs
//   ir_write   out  IR load enable
//   iord       out  memory address: 0 PC, 1 ALUOut
//   mem_rd     out  memory read request
//   mem_wr     out  memory write request
//   reg_write  out  register file write enable
//   reg_dst    out  write register: 0 rt, 1 rd, 2 r31
//   mem_to_reg out  write data: 0 ALUOut, 1 MDR, 2 PC
//   alu_src_a  out  ALU A: 0 PC, 1 rs
//   alu_src_b  out  ALU B: 0 rt, 1 const 4, 2 simm, 3 simm<<2
//   alu_cmd    out  0 ADD, 1 SUB, 2 XOR, 3 SLT
//   state      out  current state encoding (debug)
//   halted     out  high while in HALT
//
// Parameters
//   MEM_TIMEOUT  max wait cycles for mem_ready before HALT; 0 = wait forever
//
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_cmd,
  output logic [3:0] state,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_JR        = 4'd10,
    S_I_EXEC    = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_jal   = 6'h03;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_xori  = 6'h0E;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;

  localparam logic [5:0] c_fn_add   = 6'h20;
  localparam logic [5:0] c_fn_sub   = 6'h22;
  localparam logic [5:0] c_fn_slt   = 6'h2A;
  localparam logic [5:0] c_fn_jr    = 6'h08;

  localparam logic [2:0] c_alu_add  = 3'd0;
  localparam logic [2:0] c_alu_sub  = 3'd1;
  localparam logic [2:0] c_alu_xor  = 3'd2;
  localparam logic [2:0] c_alu_slt  = 3'd3;

  state_t state_q;
  state_t state_d;

  // Memory-wait qualifier shared by the next-state logic and the timeout
  // counter: only the three memory states ever look at mem_ready.
  logic w_mem_wait;
  logic w_timeout;

  // Raw (pre-reset-gating) output decode.
  logic       w_pc_en;
  logic [1:0] w_pc_src;
  logic       w_ir_write;
  logic       w_iord;
  logic       w_mem_rd;
  logic       w_mem_wr;
  logic       w_reg_write;
  logic [1:0] w_reg_dst;
  logic [1:0] w_mem_to_reg;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [2:0] w_alu_cmd;
  logic       w_halted;

  assign w_mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                       (state_q == S_MEM_WRITE)) && !mem_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Memory wait timeout
  // --------------------------------------------------------------------------
  generate
    if (MEM_TIMEOUT != 0) begin : g_timeout
      localparam int CW = $clog2(MEM_TIMEOUT + 1);
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // Counts consecutive wait cycles; any cycle that is not a memory wait
      // (including leaving the memory state) returns it to zero.
      always_comb begin
        cnt_d = '0;
        if (w_mem_wait) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // Fires on the wait cycle that brings the count up to the limit, so
      // HALT is entered exactly MEM_TIMEOUT cycles after the wait began.
      assign w_timeout = w_mem_wait && (cnt_d == CW'(MEM_TIMEOUT));
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    w_pc_en      = 1'b0;
    w_pc_src     = 2'd0;
    w_ir_write   = 1'b0;
    w_iord       = 1'b0;
    w_mem_rd     = 1'b0;
    w_mem_wr     = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 2'd0;
    w_mem_to_reg = 2'd0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'd0;
    w_alu_cmd    = c_alu_add;
    w_halted     = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 is computed here and loaded together with the IR.
        w_mem_rd    = 1'b1;
        w_alu_src_b = 2'd1;
        w_ir_write  = mem_ready;
        w_pc_en     = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (w_timeout) begin
          state_d = S_HALT;
        end
      end

      S_DECODE: begin
        // ALUOut captures the branch target speculatively.
        w_alu_src_b = 2'd3;
        case (opcode)
          c_op_rtype: begin
            if ((func == c_fn_add) || (func == c_fn_sub) || (func == c_fn_slt)) begin
              state_d = S_R_EXEC;
            end else if (func == c_fn_jr) begin
              state_d = S_JR;
            end else begin
              state_d = S_HALT;
            end
          end
          c_op_lw, c_op_sw:    state_d = S_MEM_ADR;
          c_op_beq, c_op_bne:  state_d = S_BRANCH;
          c_op_j, c_op_jal:    state_d = S_JUMP;
          c_op_addi, c_op_xori: state_d = S_I_EXEC;
          default:             state_d = S_HALT;
        endcase
      end

      S_MEM_ADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'd2;
        state_d     = (opcode == c_op_lw) ? S_MEM_READ : S_MEM_WRITE;
      end

      S_MEM_READ: begin
        w_mem_rd = 1'b1;
        w_iord   = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (w_timeout) begin
          state_d = S_HALT;
        end
      end

      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 2'd1;
        state_d      = S_FETCH;
      end

      S_MEM_WRITE: begin
        w_mem_wr = 1'b1;
        w_iord   = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (w_timeout) begin
          state_d = S_HALT;
        end
      end

      S_R_EXEC: begin
        w_alu_src_a = 1'b1;
        case (func)
          c_fn_sub: w_alu_cmd = c_alu_sub;
          c_fn_slt: w_alu_cmd = c_alu_slt;
          default:  w_alu_cmd = c_alu_add;
        endcase
        state_d = S_ALU_WB;
      end

      S_ALU_WB: begin
        // Shared by R-type (dest rd) and immediate ops (dest rt).
        w_reg_write = 1'b1;
        w_reg_dst   = (opcode == c_op_rtype) ? 2'd1 : 2'd0;
        state_d     = S_FETCH;
      end

      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_cmd   = c_alu_sub;
        w_pc_src    = 2'd1;
        w_pc_en     = ((opcode == c_op_beq) && zero) ||
                      ((opcode == c_op_bne) && !zero);
        state_d     = S_FETCH;
      end

      S_JUMP: begin
        w_pc_src = 2'd2;
        w_pc_en  = 1'b1;
        // PC already holds PC+4 from FETCH, which is the JAL return address.
        if (opcode == c_op_jal) begin
          w_reg_write  = 1'b1;
          w_reg_dst    = 2'd2;
          w_mem_to_reg = 2'd2;
        end
        state_d = S_FETCH;
      end

      S_JR: begin
        w_pc_src = 2'd3;
        w_pc_en  = 1'b1;
        state_d  = S_FETCH;
      end

      S_I_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'd2;
        w_alu_cmd   = (opcode == c_op_xori) ? c_alu_xor : c_alu_add;
        state_d     = S_ALU_WB;
      end

      S_HALT: begin
        w_halted = 1'b1;
      end

      // Encodings 13-15 can only appear through an upset; park in HALT.
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: held at zero while reset is asserted so the abandoned
  // instruction cannot write the PC, register file or memory.
  // --------------------------------------------------------------------------
  assign pc_en      = rst_n & w_pc_en;
  assign pc_src     = rst_n ? w_pc_src     : 2'd0;
  assign ir_write   = rst_n & w_ir_write;
  assign iord       = rst_n & w_iord;
  assign mem_rd     = rst_n & w_mem_rd;
  assign mem_wr     = rst_n & w_mem_wr;
  assign reg_write  = rst_n & w_reg_write;
  assign reg_dst    = rst_n ? w_reg_dst    : 2'd0;
  assign mem_to_reg = rst_n ? w_mem_to_reg : 2'd0;
  assign alu_src_a  = rst_n & w_alu_src_a;
  assign alu_src_b  = rst_n ? w_alu_src_b  : 2'd0;
  assign alu_cmd    = rst_n ? w_alu_cmd    : 3'd0;
  assign state      = rst_n ? state_q      : 4'd0;
  assign halted     = rst_n & w_halted;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control (MEM_TIMEOUT=4).
//               Each stimulus cycle pushes the expected output vector into a
//               scoreboard queue; a negedge monitor pops and compares it.
//               Expected state sequences are written out per instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  localparam int MEM_TIMEOUT = 4;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       iord;
  logic       mem_rd;
  logic       mem_wr;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_cmd;
  logic [3:0] state;
  logic       halted;

  int n_checks = 0;
  int n_errors = 0;

  string       tag_q[$];
  logic [22:0] exp_q[$];

  multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .func       (func),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .iord       (iord),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_cmd    (alu_cmd),
    .state      (state),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {pc_en, pc_src, ir_write, iord, mem_rd, mem_wr, reg_write,
  //                 reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_cmd,
  //                 state, halted}
  logic [22:0] obs;
  assign obs = {pc_en, pc_src, ir_write, iord, mem_rd, mem_wr, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_cmd,
                state, halted};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%06h exp=%06h", tag, got, exp);
    end
  endtask

  // Output table for a given state and inputs.
  function automatic logic [22:0] ref_out(input logic [3:0] st, input logic [5:0] op,
                                          input logic [5:0] fn, input logic z,
                                          input logic rdy, input logic rstn);
    logic       e_pc_en, e_ir, e_iord, e_rd, e_wr, e_rw, e_a, e_h;
    logic [1:0] e_psrc, e_rdst, e_m2r, e_b;
    logic [2:0] e_cmd;
    e_pc_en = 0; e_ir = 0; e_iord = 0; e_rd = 0; e_wr = 0; e_rw = 0; e_a = 0; e_h = 0;
    e_psrc = 0; e_rdst = 0; e_m2r = 0; e_b = 0; e_cmd = 0;
    if (!rstn) return 23'd0;
    case (st)
      4'd0:  begin e_rd = 1; e_b = 1; e_ir = rdy; e_pc_en = rdy; end
      4'd1:  begin e_b = 3; end
      4'd2:  begin e_a = 1; e_b = 2; end
      4'd3:  begin e_rd = 1; e_iord = 1; end
      4'd4:  begin e_rw = 1; e_m2r = 1; end
      4'd5:  begin e_wr = 1; e_iord = 1; end
      4'd6:  begin
        e_a = 1;
        e_cmd = (fn == 6'h22) ? 3'd1 : (fn == 6'h2A) ? 3'd3 : 3'd0;
      end
      4'd7:  begin e_rw = 1; e_rdst = (op == 6'h00) ? 2'd1 : 2'd0; end
      4'd8:  begin
        e_a = 1; e_cmd = 1; e_psrc = 1;
        e_pc_en = ((op == 6'h04) && z) || ((op == 6'h05) && !z);
      end
      4'd9:  begin
        e_psrc = 2; e_pc_en = 1;
        if (op == 6'h03) begin e_rw = 1; e_rdst = 2; e_m2r = 2; end
      end
      4'd10: begin e_psrc = 3; e_pc_en = 1; end
      4'd11: begin e_a = 1; e_b = 2; e_cmd = (op == 6'h0E) ? 3'd2 : 3'd0; end
      4'd12: begin e_h = 1; end
      default: ;
    endcase
    return {e_pc_en, e_psrc, e_ir, e_iord, e_rd, e_wr, e_rw, e_rdst, e_m2r,
            e_a, e_b, e_cmd, st, e_h};
  endfunction

  // One cycle: apply inputs just after the edge and queue the expectation
  // for the state the FSM should be in during this cycle.
  task automatic drive(input string tag, input logic rstn, input logic [5:0] op,
                       input logic [5:0] fn, input logic z, input logic rdy,
                       input logic [3:0] exp_st);
    @(posedge clk);
    #1;
    rst_n     = rstn;
    opcode    = op;
    func      = fn;
    zero      = z;
    mem_ready = rdy;
    tag_q.push_back(tag);
    exp_q.push_back(ref_out(exp_st, op, fn, z, rdy, rstn));
  endtask

  // seq holds expected states, first cycle in the low nibble; rdy bit i is
  // mem_ready during cycle i.
  task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input int n, input logic [63:0] seq,
                     input logic [15:0] rdy);
    for (int i = 0; i < n; i++) begin
      drive($sformatf("%s[%0d]", name, i), 1'b1, op, fn, z, rdy[i], seq[4*i +: 4]);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      string       t;
      logic [22:0] e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, {9'd0, obs}, {9'd0, e});
    end
  end

  initial begin
    rst_n = 1'b0; opcode = 6'h00; func = 6'h00; zero = 1'b0; mem_ready = 1'b0;

    drive("reset0", 1'b0, 6'h00, 6'h20, 1'b0, 1'b1, 4'd0);
    drive("reset1", 1'b0, 6'h00, 6'h20, 1'b0, 1'b1, 4'd0);

    run("add",      6'h00, 6'h20, 1'b0, 4, 64'h7610, 16'hFFFF);
    run("sub",      6'h00, 6'h22, 1'b0, 4, 64'h7610, 16'hFFFF);
    run("slt",      6'h00, 6'h2A, 1'b0, 4, 64'h7610, 16'hFFFF);
    run("add_fw",   6'h00, 6'h20, 1'b0, 6, 64'h761000, 16'b111100);
    run("lw_wait",  6'h23, 6'h00, 1'b0, 8, 64'h43333210, 16'b11000111);
    run("sw",       6'h2B, 6'h00, 1'b0, 4, 64'h5210, 16'hFFFF);
    run("beq_z1",   6'h04, 6'h00, 1'b1, 3, 64'h810, 16'hFFFF);
    run("beq_z0",   6'h04, 6'h00, 1'b0, 3, 64'h810, 16'hFFFF);
    run("bne_z1",   6'h05, 6'h00, 1'b1, 3, 64'h810, 16'hFFFF);
    run("bne_z0",   6'h05, 6'h00, 1'b0, 3, 64'h810, 16'hFFFF);
    run("j",        6'h02, 6'h00, 1'b0, 3, 64'h910, 16'hFFFF);
    run("jal",      6'h03, 6'h00, 1'b0, 3, 64'h910, 16'hFFFF);
    run("jr",       6'h00, 6'h08, 1'b0, 3, 64'hA10, 16'hFFFF);
    run("addi",     6'h08, 6'h2A, 1'b0, 4, 64'h7B10, 16'hFFFF);
    run("xori",     6'h0E, 6'h22, 1'b0, 4, 64'h7B10, 16'hFFFF);

    // Store with a memory that never answers: HALT 4 cycles after MEM_WRITE.
    run("sw_tmo",   6'h2B, 6'h00, 1'b0, 9, 64'hCC5555210, 16'b000000111);
    drive("rst_tmo", 1'b0, 6'h00, 6'h20, 1'b0, 1'b1, 4'd12);

    // Illegal opcode parks in HALT until reset.
    run("illegal",  6'h3F, 6'h00, 1'b0, 2, 64'h10, 16'hFFFF);
    for (int i = 0; i < 20; i++) begin
      drive($sformatf("halt_hold[%0d]", i), 1'b1, 6'h3F, 6'h00, i[0], 1'b1, 4'd12);
    end
    drive("rst_halt", 1'b0, 6'h3F, 6'h00, 1'b0, 1'b1, 4'd12);

    // Unsupported R-type func.
    run("bad_func", 6'h00, 6'h00, 1'b0, 4, 64'hCC10, 16'hFFFF);
    drive("rst_bf", 1'b0, 6'h00, 6'h00, 1'b0, 1'b1, 4'd12);

    // Reset while MEM_WRITE is waiting: outputs drop immediately, then FETCH.
    run("sw_rst",   6'h2B, 6'h00, 1'b0, 4, 64'h5210, 16'b0111);
    drive("rst_mw", 1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, 4'd5);
    // Three waits after reset must not trip the timeout (counter was cleared).
    run("sw_w3",    6'h2B, 6'h00, 1'b0, 8, 64'h05555210, 16'b11000111);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got=%0d pending exp=0 pending", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
